// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and grant FSM encoding for the request encoder/decoder pair
package cpu_pkg;

    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    typedef enum logic {
        S_IDLE    = ST_IDLE,
        S_PRESENT = ST_PRESENT
    } grant_state_e;

endpackage

// File: rtl/priority_enc_8to3.sv
// rtl/priority_enc_8to3.sv - combinational 8-to-3 encoder, highest set bit wins
module priority_enc_8to3
    import cpu_pkg::*;
(
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan upward so the highest set bit is the last (and winning) assignment.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < REQ_W; i++) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - latched request lines, registered priority grant with valid/ack
module irq_priority_encoder
    import cpu_pkg::*;
#(
    parameter int EDGE_DETECT = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [REQ_W-1:0] in,
    input  logic             ack,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    output logic [REQ_W-1:0] pending
);

    grant_state_e     state_q, state_d;
    logic [REQ_W-1:0] pending_q, pending_d;
    logic [REQ_W-1:0] in_d_q, in_d_d;
    logic [IDX_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [REQ_W-1:0] set_vec;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    priority_enc_8to3 u_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Request capture: clear the acknowledged bit first, then OR in new sets so a
    // request arriving in the same cycle as its ack is re-pended rather than lost.
    always_comb begin
        in_d_d = in;
        if (enable) begin
            set_vec = (EDGE_DETECT != 0) ? (in & ~in_d_q) : in;
        end else begin
            set_vec = '0;
        end
        pending_d = pending_q;
        if (state_q == S_PRESENT && ack) begin
            pending_d[out_q] = 1'b0;
        end
        pending_d = pending_d | set_vec;
    end

    // Grant FSM: out is only loaded on IDLE->PRESENT and held otherwise.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (enable && enc_any) begin
                    out_d   = enc_idx;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                valid_d = 1'b1;
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            in_d_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            in_d_q    <= in_d_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb/tb_irq_priority_encoder.sv - directed vector bench for edge and level capture modes
module tb_irq_priority_encoder;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       ack;
        logic       valid;
        logic [2:0] out;
        logic [7:0] pend;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] in;
    logic       ack;
    logic [2:0] e_out;
    logic       e_valid;
    logic [7:0] e_pending;
    logic [2:0] l_out;
    logic       l_valid;
    logic [7:0] l_pending;

    int total;
    int passed;

    vec_t evec[$];
    vec_t lvec[$];

    irq_priority_encoder #(.EDGE_DETECT(1)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in      (in),
        .ack     (ack),
        .out     (e_out),
        .valid   (e_valid),
        .pending (e_pending)
    );

    irq_priority_encoder #(.EDGE_DETECT(0)) u_lvl (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .in      (in),
        .ack     (ack),
        .out     (l_out),
        .valid   (l_valid),
        .pending (l_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en_i, input logic [7:0] req_i, input logic ack_i,
                                input logic v_i, input logic [2:0] o_i, input logic [7:0] p_i);
        vec_t v;
        v.en = en_i; v.req = req_i; v.ack = ack_i;
        v.valid = v_i; v.out = o_i; v.pend = p_i;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit lvl, input int row);
        enable = v.en;
        in     = v.req;
        ack    = v.ack;
        @(negedge clk);
        if (lvl) begin
            chk("lvl_valid", row, {7'd0, l_valid}, {7'd0, v.valid});
            chk("lvl_out", row, {5'd0, l_out}, {5'd0, v.out});
            chk("lvl_pending", row, l_pending, v.pend);
        end else begin
            chk("edge_valid", row, {7'd0, e_valid}, {7'd0, v.valid});
            chk("edge_out", row, {5'd0, e_out}, {5'd0, v.out});
            chk("edge_pending", row, e_pending, v.pend);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;

        //                  en  in     ack  valid out  pending
        // single request
        evec.push_back(mk(1, 8'h04, 0, 0, 3'd0, 8'h04));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd2, 8'h04));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd2, 8'h00));
        evec.push_back(mk(1, 8'h00, 0, 0, 3'd2, 8'h00));
        // priority order with ack held high (ack in IDLE ignored)
        evec.push_back(mk(1, 8'h85, 1, 0, 3'd2, 8'h85));
        evec.push_back(mk(1, 8'h00, 1, 1, 3'd7, 8'h85));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd7, 8'h05));
        evec.push_back(mk(1, 8'h00, 1, 1, 3'd2, 8'h05));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd2, 8'h01));
        evec.push_back(mk(1, 8'h00, 1, 1, 3'd0, 8'h01));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00));
        // capture gating
        evec.push_back(mk(0, 8'h10, 0, 0, 3'd0, 8'h00));
        evec.push_back(mk(0, 8'h00, 0, 0, 3'd0, 8'h00));
        evec.push_back(mk(1, 8'h10, 0, 0, 3'd0, 8'h10));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd4, 8'h10));
        // enable drop in PRESENT keeps grant; higher priority does not pre-empt
        evec.push_back(mk(0, 8'h00, 0, 1, 3'd4, 8'h10));
        evec.push_back(mk(1, 8'h80, 0, 1, 3'd4, 8'h90));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd4, 8'h80));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd7, 8'h80));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd7, 8'h00));
        // set/clear collision on bit 3
        evec.push_back(mk(1, 8'h08, 0, 0, 3'd7, 8'h08));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd3, 8'h08));
        evec.push_back(mk(1, 8'h08, 1, 0, 3'd3, 8'h08));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd3, 8'h08));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd3, 8'h00));
        evec.push_back(mk(1, 8'h00, 0, 0, 3'd3, 8'h00));
        // enable low in IDLE blocks new grants of already-pending bits
        evec.push_back(mk(1, 8'h40, 0, 0, 3'd3, 8'h40));
        evec.push_back(mk(0, 8'h00, 0, 0, 3'd3, 8'h40));
        evec.push_back(mk(1, 8'h00, 0, 1, 3'd6, 8'h40));
        evec.push_back(mk(1, 8'h00, 1, 0, 3'd6, 8'h00));

        // level mode: held request re-pends after each ack, then drains once dropped
        lvec.push_back(mk(1, 8'h01, 0, 0, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h01, 0, 1, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h01, 1, 0, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h01, 0, 1, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h01, 1, 0, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h00, 0, 1, 3'd0, 8'h01));
        lvec.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00));
        lvec.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00));
        lvec.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00));

        rst    = 1'b0;
        enable = 1'b0;
        in     = 8'h00;
        ack    = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_valid", 0, {7'd0, e_valid}, 8'h00);
        chk("reset_out", 0, {5'd0, e_out}, 8'h00);
        chk("reset_pending", 0, e_pending, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < evec.size(); i++) begin
            run_vec(evec[i], 1'b0, i);
        end

        // reset asserted mid-PRESENT with pending 8'h84 clears outputs without an edge
        run_vec(mk(1, 8'h84, 0, 0, 3'd6, 8'h84), 1'b0, 100);
        run_vec(mk(1, 8'h00, 0, 1, 3'd7, 8'h84), 1'b0, 101);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 102, {7'd0, e_valid}, 8'h00);
        chk("async_rst_out", 102, {5'd0, e_out}, 8'h00);
        chk("async_rst_pending", 102, e_pending, 8'h00);
        #1 rst = 1'b0;
        @(negedge clk);
        // late ack after reset lands in IDLE and is ignored
        run_vec(mk(1, 8'h00, 1, 0, 3'd0, 8'h00), 1'b0, 103);
        run_vec(mk(1, 8'h00, 0, 0, 3'd0, 8'h00), 1'b0, 104);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < lvec.size(); i++) begin
            run_vec(lvec[i], 1'b1, i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/irq_priority_encoder.md
# irq_priority_encoder

Registered 8-to-3 priority encoder with request latching and a valid/ack handshake: the encoding counterpart of the CPU's 3-to-8 decoder. Eight request lines are captured into a pending register. The highest-numbered pending request is presented as a 3-bit index, and that request is cleared when the consumer acknowledges it. It sits between peripheral request lines and the CPU control unit, whose decoder turns the index back into a one-hot select.

## Interface
- `EDGE_DETECT`, default 1: 1 captures rising edges of `in`; 0 captures levels.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: gates request capture and new grants.
- `in` in 8: request lines; bit 7 has the highest priority.
- `ack` in 1: consumer has taken the presented index.
- `out` out 3: index of the granted request.
- `valid` out 1: `out` holds a live grant.
- `pending` out 8: latched, not-yet-acknowledged requests.

## Operation
- Reset values (immediate on `rst`=1): `out`=0, `valid`=0, `pending`=0, internal `in_d`=0, state IDLE.
- Capture, while `enable`=1, for each bit i:
  - `EDGE_DETECT`=1: set `pending[i]` when `in[i]` & ~`in_d[i]`.
  - `EDGE_DETECT`=0: set `pending[i]` when `in[i]`.
  - `in_d` updates every cycle, whatever `enable` is.
- While `enable`=0, no new bits are set. Existing pending bits are kept.
- FSM states:
  - IDLE: `valid`=0. If `enable`=1 and `pending`≠0, register `out` = index of the highest set bit of `pending`, set `valid`=1, go to PRESENT.
  - PRESENT: `valid`=1 and `out` held stable. When `ack`=1, clear `pending[out]`, set `valid`=0, go to IDLE.
- `enable` falling while in PRESENT does not withdraw the grant. The grant stays until `ack`.
- `ack` in IDLE is ignored.
- Set and clear of the same bit in one cycle: set wins, so the request is re-pended and not lost.
- Level mode with `in[i]` still high after its ack: the bit re-pends immediately. This is intended.
- A higher-priority request arriving during PRESENT does not pre-empt. It is granted after the current ack.
- Reset asserted mid-handshake drops `valid` asynchronously. A later `ack` is then ignored because the state is IDLE.

## Timing
- Request to grant: `in` sampled high at edge N sets `pending` after N. `valid`/`out` appear after edge N+1 (2-cycle latency from first sampled high).
- Ack: `ack` sampled at edge K drops `valid` after K. The next grant, if any pending, comes after edge K+1.
- Minimum grant period is 2 cycles. Maximum throughput is one grant per 2 cycles with `ack` tied high.
- `out` only changes on the IDLE→PRESENT transition. It keeps its last value while `valid`=0.
- All outputs are registered. There is no combinational path from `in` or `ack` to any output.

## Structure
- The shared package `cpu_pkg` holds:
  - `REQ_W`=8 and `IDX_W`=3, also used by the 3-to-8 decoder.
  - State encoding localparams `ST_IDLE`=1'b0 and `ST_PRESENT`=1'b1.
- One sub-module, `priority_enc_8to3`: purely combinational. Input 8-bit vector; outputs 3-bit index of the highest set bit and `any`.
- The top level holds `pending`, `in_d`, the FSM, and the output registers.

## Test plan
- Reset: assert `rst` mid-PRESENT with `pending`=8'h84 → `valid`=0, `out`=0, `pending`=0 immediately, without a clock edge.
- Single request: `enable`=1, `in`=8'h04 for 1 cycle → `valid`=1, `out`=2 two edges later. Assert `ack` → `valid`=0, `pending`=0.
- Priority order: `in`=8'h85 in one cycle, `ack` held high → grants appear in order `out`=7, 2, 0, spaced 2 cycles apart, then `valid` stays 0.
- Gating: `enable`=0, pulse `in`=8'h10 → `pending` stays 0, no grant. Then `enable`=1 and pulse again → `out`=4.
- Set/clear collision, `EDGE_DETECT`=1: in PRESENT with `out`=3, apply `ack` together with a new rising edge on `in[3]` → `pending[3]` stays 1, and `out`=3 is granted again.
- Level mode, `EDGE_DETECT`=0: hold `in`=8'h01 → repeated grants of `out`=0 after each ack. Drop `in` → at most one further grant, then idle.
